// File: rtl/sr_latch_monitor.sv
// Purpose: clocked observer of an async active-low NAND SR latch; tracks expected state, flags mismatch/forbidden/race.
// Latency: a pin change reaches state SYNC_STAGES+1 clk edges later; every output is registered.
// Backpressure: none; passive monitor that samples its four pins every cycle.
module sr_latch_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_n,
    input  logic             latch_rst_n,
    input  logic             q,
    input  logic             qbar,
    output logic [1:0]       state,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             forbidden,
    output logic             race,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_RESET   = 2'b01,
        ST_SET     = 2'b10,
        ST_FORBID  = 2'b11
    } state_e;

    localparam int              SCNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYCLES);
    // Chain bit order {set_n, latch_rst_n, q, qbar}; idle is an undriven latch in reset.
    localparam logic [3:0]      SYNC_IDLE   = 4'b1101;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];

    logic s_n, r_n, sq, sqb;

    state_e            state_q, state_d;
    logic [SCNT_W-1:0] settle_q, settle_d;
    logic              flag_q, flag_d;
    logic              exp_valid_q, exp_valid_d;
    logic              mismatch_q, mismatch_d;
    logic              forbidden_q, forbidden_d;
    logic              race_q, race_d;
    logic [CNT_W-1:0]  err_q, err_d;

    logic              learn;
    logic              change;
    logic [1:0]        exp_pair;

    // Shift the raw asynchronous pins one stage deeper into each synchronizer chain
    always_comb begin
        sync_d[0] = {set_n, latch_rst_n, q, qbar};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchronizer flops, returned to the idle pin pattern on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_IDLE;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign {s_n, r_n, sq, sqb} = sync_q[SYNC_STAGES-1];

    // Reference latch model, settle countdown, episode-based mismatch checking
    always_comb begin
        state_d  = state_q;
        learn    = 1'b0;
        race_d   = 1'b0;
        exp_pair = 2'b00;

        unique case ({s_n, r_n})
            2'b01:   state_d = ST_SET;
            2'b10:   state_d = ST_RESET;
            2'b00:   state_d = ST_FORBID;
            default: begin
                if (state_q == ST_FORBID) begin
                    // Simultaneous release: the real latch resolves unpredictably.
                    state_d = ST_UNKNOWN;
                    race_d  = 1'b1;
                end else if (state_q == ST_UNKNOWN && settle_q == '0 && sq != sqb) begin
                    // Adopt whatever stable state the latch is showing.
                    state_d = sq ? ST_SET : ST_RESET;
                    learn   = 1'b1;
                end
            end
        endcase

        change = (state_d != state_q) && !learn;

        unique case (state_q)
            ST_SET:    exp_pair = 2'b10;
            ST_RESET:  exp_pair = 2'b01;
            ST_FORBID: exp_pair = 2'b11;
            default:   exp_pair = 2'b00;
        endcase

        if (change) begin
            settle_d = SETTLE_LOAD;
        end else if (settle_q != '0) begin
            settle_d = settle_q - SCNT_W'(1);
        end else begin
            settle_d = settle_q;
        end

        // A state change on the same edge suppresses a check against the old state.
        mismatch_d = !change && exp_valid_q && ({sq, sqb} != exp_pair) && !flag_q;

        if (change) begin
            flag_d = 1'b0;
        end else if (mismatch_d) begin
            flag_d = 1'b1;
        end else begin
            flag_d = flag_q;
        end

        if (mismatch_d && err_q != {CNT_W{1'b1}}) begin
            err_d = err_q + CNT_W'(1);
        end else begin
            err_d = err_q;
        end

        exp_valid_d = (state_d != ST_UNKNOWN) && (settle_d == '0);
        forbidden_d = (state_d == ST_FORBID);
    end

    // Model state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNKNOWN;
            settle_q    <= '0;
            flag_q      <= 1'b0;
            exp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            forbidden_q <= 1'b0;
            race_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            flag_q      <= flag_d;
            exp_valid_q <= exp_valid_d;
            mismatch_q  <= mismatch_d;
            forbidden_q <= forbidden_d;
            race_q      <= race_d;
            err_q       <= err_d;
        end
    end

    assign state     = state_q;
    assign exp_valid = exp_valid_q;
    assign mismatch  = mismatch_q;
    assign forbidden = forbidden_q;
    assign race      = race_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Bench for sr_latch_monitor: directed table + hand sequences + random latch activity vs an event-level model.
// Two instances share all pins; the second uses a 2-bit error counter to exercise saturation.
// Outputs are sampled on the falling clock edge; pins are driven right after sampling.
module tb_sr_latch_monitor;

    localparam int SYNC   = 2;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       set_n = 1'b1, latch_rst_n = 1'b1, q = 1'b0, qbar = 1'b1;

    logic [1:0] state, state2;
    logic       exp_valid, mismatch, forbidden, race;
    logic       exp_valid2, mismatch2, forbidden2, race2;
    logic [7:0] err_count;
    logic [1:0] err2;

    int tests = 0;
    int fails = 0;
    int mism_cnt = 0;
    int race_cnt = 0;

    always #5 clk = ~clk;

    sr_latch_monitor #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .set_n(set_n), .latch_rst_n(latch_rst_n), .q(q), .qbar(qbar),
        .state(state), .exp_valid(exp_valid), .mismatch(mismatch), .forbidden(forbidden),
        .race(race), .err_count(err_count)
    );

    sr_latch_monitor #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .set_n(set_n), .latch_rst_n(latch_rst_n), .q(q), .qbar(qbar),
        .state(state2), .exp_valid(exp_valid2), .mismatch(mismatch2), .forbidden(forbidden2),
        .race(race2), .err_count(err2)
    );

    // ---------------- event-level reference model ----------------
    // State codes: 0 UNKNOWN, 1 RESET, 2 SET, 3 FORBID. Settling is tracked as
    // "edges since the last change"; episodes are numbered and an episode is
    // counted at most once.
    int         m_state, m_cyc, m_chg, m_ep, m_flag_ep, m_err;
    bit         m_valid, m_mism, m_race;
    logic [3:0] m_hist[$];   // pin samples {set_n, latch_rst_n, q, qbar}, oldest first
    logic [3:0] m_syn;
    int         m_nxt;
    bit         m_learn, m_change, m_old_zero;
    logic [1:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_cyc = 0; m_chg = -1000; m_ep = 0; m_flag_ep = -1; m_err = 0;
            m_valid = 0; m_mism = 0; m_race = 0;
            m_hist.delete();
            for (int i = 0; i < SYNC; i++) m_hist.push_back(4'b1101);
        end else begin
            m_cyc = m_cyc + 1;
            m_syn = m_hist.pop_front();
            m_hist.push_back({set_n, latch_rst_n, q, qbar});
            m_old_zero = ((m_cyc - 1 - m_chg) >= SETTLE);
            m_learn = 0;
            m_race = 0;
            if (m_syn[3:2] == 2'b01)      m_nxt = 2;
            else if (m_syn[3:2] == 2'b10) m_nxt = 1;
            else if (m_syn[3:2] == 2'b00) m_nxt = 3;
            else if (m_state == 3) begin m_nxt = 0; m_race = 1; end
            else if (m_state == 0 && m_old_zero && m_syn[1] != m_syn[0]) begin
                m_nxt = m_syn[1] ? 2 : 1;
                m_learn = 1;
            end else m_nxt = m_state;
            m_change = (m_nxt != m_state) && !m_learn;
            m_exp = (m_state == 2) ? 2'b10 : (m_state == 1) ? 2'b01 : 2'b11;
            m_mism = !m_change && m_valid && (m_syn[1:0] != m_exp) && (m_flag_ep != m_ep);
            if (m_change) begin m_chg = m_cyc; m_ep = m_ep + 1; end
            if (m_mism) begin m_flag_ep = m_ep; m_err = m_err + 1; end
            m_state = m_nxt;
            m_valid = (m_nxt != 0) && ((m_cyc - m_chg) >= SETTLE);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] outs();
        return {state, exp_valid, mismatch, forbidden, race, err_count, err2,
                state2, exp_valid2, mismatch2, forbidden2, race2};
    endfunction

    task automatic tick();
        int e8, e2;
        logic [21:0] exp;
        @(negedge clk);
        e8 = (m_err > 255) ? 255 : m_err;
        e2 = (m_err > 3) ? 3 : m_err;
        exp = {m_state[1:0], m_valid, m_mism, (m_state == 3), m_race, e8[7:0], e2[1:0],
               m_state[1:0], m_valid, m_mism, (m_state == 3), m_race};
        check($sformatf("model_cyc%0d", m_cyc), 32'(outs()), 32'(exp));
        if (mismatch) mism_cnt++;
        if (race) race_cnt++;
    endtask

    task automatic drive(input int s, input int r, input int qq, input int qb);
        set_n = s[0]; latch_rst_n = r[0]; q = qq[0]; qbar = qb[0];
    endtask

    typedef struct {
        int s, r, qq, qb, cyc;
        int st, valid, forb, err, err2, mism, race;
    } vec_t;

    function automatic vec_t mk(int s, int r, int qq, int qb, int cyc, int st, int valid,
                                int forb, int err, int e2, int mism, int rc);
        vec_t v;
        v.s = s; v.r = r; v.qq = qq; v.qb = qb; v.cyc = cyc;
        v.st = st; v.valid = valid; v.forb = forb; v.err = err; v.err2 = e2;
        v.mism = mism; v.race = rc;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        vec_t tbl[$];
        int ctl;
        bit lq, lqb;

        //            s r q qb cyc  st v f err e2 mism race
        tbl.push_back(mk(1,1,0,1, 3,  1,1,0, 0,0, 0,0));   // idle q/qbar learned as RESET
        tbl.push_back(mk(0,1,0,1, 1,  1,1,0, 0,0, 0,0));   // set_n asserted, q lags one cycle
        tbl.push_back(mk(0,1,1,0, 1,  1,1,0, 0,0, 0,0));
        tbl.push_back(mk(0,1,1,0, 1,  2,0,0, 0,0, 0,0));   // SET on third edge, settling
        tbl.push_back(mk(0,1,1,0, 2,  2,1,0, 0,0, 0,0));   // settled two edges later
        tbl.push_back(mk(1,1,1,0, 3,  2,1,0, 0,0, 0,0));   // release holds SET
        tbl.push_back(mk(1,0,1,0, 3,  1,0,0, 0,0, 0,0));   // reset with q stuck high
        tbl.push_back(mk(1,0,1,0, 2,  1,1,0, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,0, 1,  1,1,0, 1,1, 1,0));   // single mismatch
        tbl.push_back(mk(1,0,1,0,20,  1,1,0, 1,1, 1,0));   // not recounted
        tbl.push_back(mk(0,0,1,1, 3,  3,0,1, 1,1, 1,0));   // forbidden
        tbl.push_back(mk(0,0,1,1, 2,  3,1,1, 1,1, 1,0));
        tbl.push_back(mk(1,1,1,1, 3,  0,0,0, 1,1, 1,1));   // simultaneous release -> race
        tbl.push_back(mk(1,1,1,1, 3,  0,0,0, 1,1, 1,1));   // q==qbar: stays unknown
        tbl.push_back(mk(1,1,0,1, 1,  0,0,0, 1,1, 1,1));
        tbl.push_back(mk(1,1,0,1, 2,  1,1,0, 1,1, 1,1));   // learned RESET, no error
        tbl.push_back(mk(1,1,0,1, 3,  1,1,0, 1,1, 1,1));
        tbl.push_back(mk(0,1,0,1, 6,  2,1,0, 2,2, 2,1));   // episode 1
        tbl.push_back(mk(1,1,0,1, 1,  2,1,0, 2,2, 2,1));
        tbl.push_back(mk(1,0,1,0, 6,  1,1,0, 3,3, 3,1));   // episode 2
        tbl.push_back(mk(1,1,1,0, 1,  1,1,0, 3,3, 3,1));
        tbl.push_back(mk(0,1,0,1, 6,  2,1,0, 4,3, 4,1));   // episode 3, 2-bit counter saturated
        tbl.push_back(mk(1,1,0,1, 1,  2,1,0, 4,3, 4,1));
        tbl.push_back(mk(1,0,1,0, 6,  1,1,0, 5,3, 5,1));   // episode 4
        tbl.push_back(mk(1,1,1,0, 1,  1,1,0, 5,3, 5,1));
        tbl.push_back(mk(0,1,0,1, 6,  2,1,0, 6,3, 6,1));   // episode 5

        // Reset with idle pins
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        #1 check("post_reset_outputs", 32'(outs()), 32'd0);

        // Directed table
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].r, tbl[i].qq, tbl[i].qb);
            repeat (tbl[i].cyc) tick();
            check($sformatf("row%0d_state", i), 32'(state), tbl[i].st);
            check($sformatf("row%0d_flags", i), 32'({exp_valid, forbidden}),
                  32'((tbl[i].valid << 1) | tbl[i].forb));
            check($sformatf("row%0d_err", i), 32'(err_count), tbl[i].err);
            check($sformatf("row%0d_err_sat", i), 32'(err2), tbl[i].err2);
            check($sformatf("row%0d_pulses", i), mism_cnt * 256 + race_cnt,
                  tbl[i].mism * 256 + tbl[i].race);
        end

        // Async reset in the middle of a settle countdown in SET
        drive(1, 0, 1, 0);
        repeat (3) tick();
        drive(0, 1, 1, 0);
        repeat (3) tick();
        check("pre_rst_settling", 32'({state, exp_valid}), 32'({2'b10, 1'b0}));
        #2 rst_n = 1'b0;
        #1 check("async_rst_outputs", 32'(outs()), 32'd0);
        drive(1, 1, 0, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        #1 check("release_state", 32'(state), 32'd0);
        repeat (3) tick();
        check("relearn_reset", 32'({state, err_count}), 32'({2'b01, 8'd0}));

        // Random latch activity against the model
        ctl = 3; lq = 1'b0; lqb = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 6))
                    0, 1, 2, 3: ctl = 3;
                    4:          ctl = 1;
                    5:          ctl = 2;
                    default:    ctl = 0;
                endcase
            end
            case (ctl)
                1: begin lq = 1'b1; lqb = 1'b0; end
                2: begin lq = 1'b0; lqb = 1'b1; end
                0: begin lq = 1'b1; lqb = 1'b1; end
                default: if (lq == lqb) begin lq = $urandom_range(0, 1) != 0; lqb = !lq; end
            endcase
            if ($urandom_range(0, 11) == 0) drive(ctl[1], ctl[0], $urandom_range(0, 1), $urandom_range(0, 1));
            else drive(ctl[1], ctl[0], lq, lqb);
            if (n == 1500) begin
                rst_n = 1'b0;
                #1 check("rand_async_rst", 32'(outs()), 32'd0);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
